// File: rtl/top_module_jkff_pkg.sv
// ---------------------------------------------------------------------------
// top_module_jkff_pkg
// Shared definitions for the JK flip-flop bank.
//   jk_op_e : the four per-bit actions a JK flop can take on a clock edge
//   jkOp()  : decodes a J/K input pair into one of those actions
// ---------------------------------------------------------------------------
package top_module_jkff_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_op_e;

    // The enum encoding lines up with {J,K}, so decoding is a straight cast.
    function automatic jk_op_e jkOp(input logic j, input logic k);
        return jk_op_e'({j, k});
    endfunction

endpackage

// File: rtl/top_module_jkff_jk_bit.sv
// ---------------------------------------------------------------------------
// top_module_jkff_jk_bit
// One JK flip-flop with a per-bit clock enable and a synchronous reset.
//   clk_i   : rising-edge clock
//   reset_i : synchronous, active-high; loads RESET_VAL regardless of J/K/en
//   j_i     : set / toggle control
//   k_i     : clear / toggle control
//   en_i    : clock enable; when low the flop holds
//   q_o     : registered state
// ---------------------------------------------------------------------------
module top_module_jkff_jk_bit
    import top_module_jkff_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic j_i,
    input  logic k_i,
    input  logic en_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    // Next state from the JK truth table; only consumed when enabled.
    always_comb begin
        q_d = q_q;
        unique case (jkOp(j_i, k_i))
            JK_HOLD: q_d = q_q;
            JK_CLR:  q_d = 1'b0;
            JK_SET:  q_d = 1'b1;
            JK_TGL:  q_d = ~q_q;
        endcase
    end

    // Reset outranks the enable, which outranks the J/K action.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_q <= RESET_VAL;
        end else if (en_i) begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/top_module_jkff.sv
// ---------------------------------------------------------------------------
// top_module_jkff
// Bank of WIDTH independent JK flip-flops on one clock with one synchronous
// reset. Each bit sets, clears, holds or toggles under its own J/K pair.
//   J     : per-bit set/toggle control
//   K     : per-bit clear/toggle control
//   clk   : rising-edge clock
//   Q     : registered state
//   reset : synchronous, active-high; Q <= RESET_VAL
//   en    : per-bit clock enable, active-high
//   Qn    : combinational complement of Q
// Port order keeps the legacy positional hookup (J, K, clk, Q) usable.
// EN_USED=0 ignores en and runs every bit as always enabled, which is the
// setting to use when en is left unconnected.
// ---------------------------------------------------------------------------
module top_module_jkff
    import top_module_jkff_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               EN_USED   = 1'b1
) (
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             clk,
    output logic [WIDTH-1:0] Q,
    input  logic             reset,
    input  logic [WIDTH-1:0] en,
    output logic [WIDTH-1:0] Qn
);

    logic [WIDTH-1:0] enEff;

    // OR-ing in the tie-off keeps en referenced even when it is ignored.
    assign enEff = en | {WIDTH{~EN_USED}};

    for (genvar i = 0; i < WIDTH; i++) begin : gBit
        top_module_jkff_jk_bit #(
            .RESET_VAL (RESET_VAL[i])
        ) uBit (
            .clk_i   (clk),
            .reset_i (reset),
            .j_i     (J[i]),
            .k_i     (K[i]),
            .en_i    (enEff[i]),
            .q_o     (Q[i])
        );
    end

    assign Qn = ~Q;

endmodule

// File: tb/tb_top_module_jkff.sv
// ---------------------------------------------------------------------------
// tb_top_module_jkff
// Drives three JK banks (1-bit reset-to-0, 1-bit reset-to-1, 4-bit reset to
// 4'b0101) with directed vectors, tracks the expected state of every bit in
// a behavioural model and checks Q/Qn against it every cycle, plus literal
// expectations at the key points of each scenario.
// ---------------------------------------------------------------------------
module tb_top_module_jkff;

    logic       clk;
    logic       rst;
    logic       jA, kA, enA;
    logic [3:0] jB, kB, enB;
    logic       qA, qnA, qC, qnC;
    logic [3:0] qB, qnB;

    int checks = 0;
    int errors = 0;

    // Expected state and which bits of it are defined (a bit stays unknown
    // until a reset, set or clear pins it).
    logic [3:0] mA = 4'b0, mC = 4'b0, mB = 4'b0;
    logic [3:0] kmA = 4'b0, kmC = 4'b0, kmB = 4'b0;

    top_module_jkff #(.WIDTH(1), .RESET_VAL(1'b0)) dutA (
        .J(jA), .K(kA), .clk(clk), .Q(qA), .reset(rst), .en(enA), .Qn(qnA)
    );

    top_module_jkff #(.WIDTH(1), .RESET_VAL(1'b1)) dutC (
        .J(jA), .K(kA), .clk(clk), .Q(qC), .reset(rst), .en(enA), .Qn(qnC)
    );

    top_module_jkff #(.WIDTH(4), .RESET_VAL(4'b0101)) dutB (
        .J(jB), .K(kB), .clk(clk), .Q(qB), .reset(rst), .en(enB), .Qn(qnB)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One edge of the JK behaviour, described bit by bit from the truth table.
    function automatic logic [3:0] nextState(input logic [3:0] q, input logic [3:0] j,
                                             input logic [3:0] k, input logic [3:0] en,
                                             input logic r, input logic [3:0] rv);
        logic [3:0] n;
        n = q;
        for (int i = 0; i < 4; i++) begin
            if (r)                   n[i] = rv[i];
            else if (!en[i])         n[i] = q[i];
            else if (j[i] && !k[i])  n[i] = 1'b1;
            else if (!j[i] && k[i])  n[i] = 1'b0;
            else if (j[i] && k[i])   n[i] = ~q[i];
        end
        return n;
    endfunction

    function automatic logic [3:0] nextKnown(input logic [3:0] km, input logic [3:0] j,
                                             input logic [3:0] k, input logic [3:0] en,
                                             input logic r);
        if (r) return 4'hF;
        return km | (en & (j ^ k));
    endfunction

    // Advance the model on every rising edge from the inputs the DUTs see.
    always @(posedge clk) begin
        mA  = nextState(mA, {3'b0, jA}, {3'b0, kA}, {3'b0, enA}, rst, 4'b0000);
        kmA = nextKnown(kmA, {3'b0, jA}, {3'b0, kA}, {3'b0, enA}, rst) & 4'b0001;
        mC  = nextState(mC, {3'b0, jA}, {3'b0, kA}, {3'b0, enA}, rst, 4'b0001);
        kmC = nextKnown(kmC, {3'b0, jA}, {3'b0, kA}, {3'b0, enA}, rst) & 4'b0001;
        mB  = nextState(mB, jB, kB, enB, rst, 4'b0101);
        kmB = nextKnown(kmB, jB, kB, enB, rst);
    end

    task automatic cmpModel(input string name, input logic [3:0] q, input logic [3:0] qn,
                            input logic [3:0] m, input logic [3:0] km);
        if (km != 4'b0) begin
            checks++;
            if ((((q ^ m) | (qn ^ ~m)) & km) != 4'b0) begin
                errors++;
                $display("[TB] FAIL %s model: Q=%b Qn=%b expected Q=%b (known mask %b)",
                         name, q, qn, m, km);
            end
        end
    endtask

    // Every falling edge, compare each bank's defined bits against the model.
    always @(negedge clk) begin
        cmpModel("dutA", {3'b0, qA}, {3'b0, qnA}, mA, kmA);
        cmpModel("dutC", {3'b0, qC}, {3'b0, qnC}, mC, kmC);
        cmpModel("dutB", qB, qnB, mB, kmB);
    end

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Set inputs, let exactly one rising edge pass, then settle mid-low phase.
    task automatic applyStimulus(input logic r, input logic j1, input logic k1, input logic e1,
                                 input logic [3:0] j4, input logic [3:0] k4, input logic [3:0] e4);
        rst = r; jA = j1; kA = k1; enA = e1; jB = j4; kB = k4; enB = e4;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; jA = 1'b0; kA = 1'b0; enA = 1'b1;
        jB = 4'h0; kB = 4'h0; enB = 4'hF;
        @(negedge clk);
        #1;

        // Truth table from the power-up unknown state: JK = 01,10,11,00,01
        applyStimulus(0, 0, 1, 1, 4'h0, 4'h0, 4'hF);
        checkOutput("tt edge1 clr", {3'b0, qA}, 4'b0000);
        applyStimulus(0, 1, 0, 1, 4'h0, 4'h0, 4'hF);
        checkOutput("tt edge2 set", {3'b0, qA}, 4'b0001);
        applyStimulus(0, 1, 1, 1, 4'h0, 4'h0, 4'hF);
        checkOutput("tt edge3 tgl", {3'b0, qA}, 4'b0000);
        applyStimulus(0, 0, 0, 1, 4'h0, 4'h0, 4'hF);
        checkOutput("tt edge4 hold", {3'b0, qA}, 4'b0000);
        applyStimulus(0, 0, 1, 1, 4'h0, 4'h0, 4'hF);
        checkOutput("tt edge5 clr", {3'b0, qA}, 4'b0000);

        // Reset with J=K=1 everywhere: reset must win
        applyStimulus(1, 1, 1, 1, 4'hF, 4'hF, 4'hF);
        checkOutput("reset A Q",  {3'b0, qA},  4'b0000);
        checkOutput("reset A Qn", {3'b0, qnA}, 4'b0001);
        checkOutput("reset C Q",  {3'b0, qC},  4'b0001);
        checkOutput("reset C Qn", {3'b0, qnC}, 4'b0000);
        checkOutput("reset B Q",  qB,  4'b0101);
        checkOutput("reset B Qn", qnB, 4'b1010);

        // Repeated toggle: A goes 1,0,1,0 and C goes 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, 1, 4'h0, 4'h0, 4'hF);
            checkOutput($sformatf("toggle%0d A", i), {3'b0, qA}, (i % 2 == 0) ? 4'b0001 : 4'b0000);
            checkOutput($sformatf("toggle%0d C", i), {3'b0, qC}, (i % 2 == 0) ? 4'b0000 : 4'b0001);
        end

        // Enable: en=0 blocks a set, en=1 lets it through
        applyStimulus(0, 1, 0, 0, 4'h0, 4'h0, 4'hF);
        checkOutput("en0 hold A", {3'b0, qA}, 4'b0000);
        applyStimulus(0, 1, 0, 1, 4'h0, 4'h0, 4'hF);
        checkOutput("en1 set A", {3'b0, qA}, 4'b0001);

        // Mid-operation reset discards the set sampled on the same edge
        applyStimulus(1, 1, 0, 1, 4'h0, 4'h0, 4'hF);
        checkOutput("midreset A", {3'b0, qA}, 4'b0000);
        checkOutput("midreset B", qB, 4'b0101);
        applyStimulus(0, 1, 0, 1, 4'h0, 4'h0, 4'hF);
        checkOutput("release A", {3'b0, qA}, 4'b0001);

        // 4-bit bank: 0101 -> 0011 (clear bit2, set bit1), then mixed ops
        applyStimulus(0, 0, 0, 1, 4'b0010, 4'b0100, 4'hF);
        checkOutput("B to 0011", qB, 4'b0011);
        applyStimulus(0, 0, 0, 1, 4'b1010, 4'b0110, 4'hF);
        checkOutput("B mixed ops", qB, 4'b1001);
        checkOutput("B mixed Qn", qnB, 4'b0110);

        // Per-bit enable: only bits 2:1 toggle
        applyStimulus(0, 0, 0, 1, 4'hF, 4'hF, 4'b0110);
        checkOutput("B per-bit en", qB, 4'b1111);
        applyStimulus(0, 0, 0, 1, 4'b0000, 4'b1111, 4'b1001);
        checkOutput("B per-bit clr", qB, 4'b0110);

        applyStimulus(0, 0, 0, 1, 4'h0, 4'h0, 4'hF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Upper bound on run time in case the stimulus ever stalls.
    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
